buzzer_sched: RTL

Scheduler that shares the single alarm buzzer between three alarm requesters (one per sensor channel). Each request is latched as pending. An arbiter grants the buzzer to one channel at a time for a fixed on-time, then enforces a silent gap before the next grant. It sits between the per-channel sensor debounce logic and the buzzer output pin, and reports which channel is sounding and when each alarm has completed.

---
 rtl/buzzer_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/buzzer_sched.sv
// buzzer_sched: shares one alarm buzzer between three sensor channels.
// Requests are latched as pending. An arbiter (fixed priority or round-robin)
// grants the buzzer for ON_CYCLES cycles and then forces GAP_CYCLES silent
// cycles before the next grant. A one-cycle done pulse reports each
// completed on-time together with the channel index.
module buzzer_sched #(
   parameter int unsigned ON_CYCLES  = 31,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [2:0] req,
   input  logic       prio_mode,
   input  logic       clear,
   output logic       buzz,
   output logic [2:0] grant,
   output logic [2:0] pending,
   output logic       busy,
   output logic       done,
   output logic [1:0] done_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [4:0] ON_LIM  = 5'(ON_CYCLES);
   localparam logic [4:0] GAP_LIM = 5'(GAP_CYCLES);

   state_t     state_r;
   logic [4:0] cnt_r;
   logic [1:0] rr_last_r;
   logic [1:0] cur_r;
   logic [1:0] winner_s;
   logic [2:0] served_s;

   // Lowest pending index wins.
   function automatic logic [1:0] pick_fixed(input logic [2:0] p);
      logic [1:0] w;
      if (p[0]) begin
         w = 2'd0;
      end else if (p[1]) begin
         w = 2'd1;
      end else begin
         w = 2'd2;
      end
      return w;
   endfunction

   // First pending index searched cyclically, starting just after last.
   function automatic logic [1:0] pick_rr(input logic [2:0] p, input logic [1:0] last);
      logic [1:0] w;
      case (last)
         2'd0: begin
            if (p[1]) begin
               w = 2'd1;
            end else if (p[2]) begin
               w = 2'd2;
            end else begin
               w = 2'd0;
            end
         end
         2'd1: begin
            if (p[2]) begin
               w = 2'd2;
            end else if (p[0]) begin
               w = 2'd0;
            end else begin
               w = 2'd1;
            end
         end
         default: w = pick_fixed(p);
      endcase
      return w;
   endfunction

   // Arbitration: winner among pending channels and the bit it consumes.
   always_comb begin
      winner_s = 2'd0;
      served_s = 3'b000;
      if (prio_mode) begin
         winner_s = pick_rr(pending, rr_last_r);
      end else begin
         winner_s = pick_fixed(pending);
      end
      if ((state_r == IDLE) && (pending != 3'b000)) begin
         served_s = 3'b001 << winner_s;
      end else begin
         served_s = 3'b000;
      end
   end

   // busy is a pure decode of the registered state.
   always_comb begin
      busy = 1'b0;
      if (state_r != IDLE) begin
         busy = 1'b1;
      end else begin
         busy = 1'b0;
      end
   end

   // Request latching, IDLE/ON/GAP sequencing and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= 5'd0;
         rr_last_r <= 2'd2;
         cur_r     <= 2'd0;
         pending   <= 3'b000;
         buzz      <= 1'b0;
         grant     <= 3'b000;
         done      <= 1'b0;
         done_id   <= 2'd0;
      end else if (ena) begin
         if (clear) begin
            // Flush: abort any grant silently; round-robin history is kept.
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            pending <= 3'b000;
            buzz    <= 1'b0;
            grant   <= 3'b000;
            done    <= 1'b0;
         end else begin
            // A new request on the serving edge re-sets the bit (set wins).
            pending <= (pending & ~served_s) | req;
            done    <= 1'b0;
            case (state_r)
               IDLE: begin
                  if (pending != 3'b000) begin
                     grant     <= served_s;
                     buzz      <= 1'b1;
                     cnt_r     <= 5'd1;
                     rr_last_r <= winner_s;
                     cur_r     <= winner_s;
                     state_r   <= ON;
                  end
               end
               ON: begin
                  if (cnt_r == ON_LIM) begin
                     buzz    <= 1'b0;
                     grant   <= 3'b000;
                     done    <= 1'b1;
                     done_id <= cur_r;
                     if (GAP_LIM == 5'd0) begin
                        cnt_r   <= 5'd0;
                        state_r <= IDLE;
                     end else begin
                        cnt_r   <= 5'd1;
                        state_r <= GAP;
                     end
                  end else begin
                     cnt_r <= cnt_r + 5'd1;
                  end
               end
               GAP: begin
                  if (cnt_r == GAP_LIM) begin
                     cnt_r   <= 5'd0;
                     state_r <= IDLE;
                  end else begin
                     cnt_r <= cnt_r + 5'd1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  cnt_r   <= 5'd0;
                  buzz    <= 1'b0;
                  grant   <= 3'b000;
               end
            endcase
         end
      end
   end

endmodule
